// File: rtl/me_lsu.sv
// Memory-stage load/store unit: converts the ME instruction into a req/ready
// data-memory transaction and returns aligned, extended load data.
module me_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    me_valid,
  input  logic                    me_mem_read,
  input  logic                    me_mem_write,
  input  logic [2:0]              me_funct3,
  input  logic [DATA_WIDTH-1:0]   me_addr,
  input  logic [DATA_WIDTH-1:0]   me_wdata,
  output logic [DATA_WIDTH-1:0]   me_mem_rdata,
  output logic                    me_stall,
  output logic                    me_mem_exc,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [DATA_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [3:0]              dmem_be,
  input  logic                    dmem_ready,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  access;
  logic                  illegal;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  assign access = me_valid & (me_mem_read | me_mem_write);

  always_comb begin
    illegal = 1'b0;
    if (me_funct3[1:0] == 2'b11) begin
      illegal = 1'b1;
    end else if (me_mem_write && me_funct3 == 3'd6) begin
      illegal = 1'b1;
    end else if (me_funct3[1:0] == 2'b01 && me_addr[0]) begin
      illegal = 1'b1;
    end else if (me_funct3[1:0] == 2'b10 && me_addr[1:0] != 2'b00) begin
      illegal = 1'b1;
    end
  end

  // Byte enables are generated for loads too, so the memory sees the accessed lanes.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = me_wdata;
    case (me_funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << me_addr[1:0];
        lane_wdata = {4{me_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = me_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{me_wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = me_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   ld_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    rdata_d    = rdata_q;
    me_stall   = 1'b0;
    me_mem_exc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (illegal) begin
            me_mem_exc = 1'b1;
          end else begin
            me_stall = 1'b1;
            req_d    = 1'b1;
            we_d     = me_mem_write;
            be_d     = lane_be;
            addr_d   = {me_addr[DATA_WIDTH-1:2], 2'b00};
            wdata_d  = lane_wdata;
            funct3_d = me_funct3;
            off_d    = me_addr[1:0];
            cnt_d    = 8'd0;
            state_d  = StAccess;
          end
        end
      end
      StAccess: begin
        me_stall = 1'b1;
        if (dmem_ready) begin
          rdata_d = we_q ? '0 : ld_ext;
          req_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        // ME still holds the finished instruction here, so never re-issue.
        me_mem_exc = tmo_q;
        tmo_d      = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      cnt_q    <= 8'd0;
      tmo_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_be      = be_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign me_mem_rdata = rdata_q;

endmodule

// File: tb/tb_me_lsu.sv
// Directed testbench for me_lsu: loads, stores, wait states, exceptions,
// timeout, mid-access reset and back-to-back issue.
module tb_me_lsu;

  logic        clk;
  logic        rst_n;
  logic        me_valid;
  logic        me_mem_read;
  logic        me_mem_write;
  logic [2:0]  me_funct3;
  logic [31:0] me_addr;
  logic [31:0] me_wdata;
  logic [31:0] me_mem_rdata;
  logic        me_stall;
  logic        me_mem_exc;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int checks;
  int failures;
  int req_rises;
  logic req_prev;

  me_lsu #(
    .DATA_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .me_valid    (me_valid),
    .me_mem_read (me_mem_read),
    .me_mem_write(me_mem_write),
    .me_funct3   (me_funct3),
    .me_addr     (me_addr),
    .me_wdata    (me_wdata),
    .me_mem_rdata(me_mem_rdata),
    .me_stall    (me_stall),
    .me_mem_exc  (me_mem_exc),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ready  (dmem_ready),
    .dmem_rdata  (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dmem_req && !req_prev) req_rises++;
    req_prev = dmem_req;
  end

  // Presents a memory instruction, services it after 'waits' wait cycles, checks
  // the ACCESS outputs and the DONE result. Leaves the instruction held in DONE.
  task automatic do_access(input string name, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input logic [31:0] rword,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    int stalls;
    int rises0;
    stalls = 0;
    @(negedge clk);
    me_valid     = 1'b1;
    me_mem_read  = ~wr;
    me_mem_write = wr;
    me_funct3    = f3;
    me_addr      = addr;
    me_wdata     = wd;
    dmem_ready   = 1'b0;
    rises0       = req_rises;
    #1;
    if (me_stall) stalls++;
    checks++;
    if (me_mem_exc !== 1'b0) begin
      failures++;
      $display("FAIL %s issue_exc: got %b want 0", name, me_mem_exc);
    end
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      if (me_stall) stalls++;
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_be !== exp_be ||
          dmem_we !== wr) begin
        failures++;
        $display("FAIL %s access%0d: req=%b addr=%h be=%b we=%b want req=1 addr=%h be=%b we=%b",
                 name, i, dmem_req, dmem_addr, dmem_be, dmem_we, exp_addr, exp_be, wr);
      end
      if (wr) begin
        checks++;
        if (dmem_wdata !== exp_wdata) begin
          failures++;
          $display("FAIL %s wdata: got %h want %h", name, dmem_wdata, exp_wdata);
        end
      end
      dmem_ready = (i == waits);
      dmem_rdata = (i == waits) ? rword : 32'h0BAD_F00D;
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    checks++;
    if (me_stall !== 1'b0 || me_mem_exc !== 1'b0 || me_mem_rdata !== exp_rdata ||
        dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s done: stall=%b exc=%b rdata=%h req=%b want 0 0 %h 0",
               name, me_stall, me_mem_exc, me_mem_rdata, dmem_req, exp_rdata);
    end
    checks++;
    if (stalls != waits + 2 || req_rises != rises0 + 1) begin
      failures++;
      $display("FAIL %s stall_count: stalls=%0d reqs=%0d want %0d 1",
               name, stalls, req_rises - rises0, waits + 2);
    end
  endtask

  // Non-memory instruction with a stray ready: nothing may move.
  task automatic idle_cycle(input string name);
    logic [31:0] held;
    @(negedge clk);
    held         = me_mem_rdata;
    me_valid     = 1'b1;
    me_mem_read  = 1'b0;
    me_mem_write = 1'b0;
    dmem_ready   = 1'b1;
    dmem_rdata   = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (me_stall !== 1'b0 || dmem_req !== 1'b0 || me_mem_exc !== 1'b0) begin
      failures++;
      $display("FAIL %s idle: stall=%b req=%b exc=%b want 0 0 0",
               name, me_stall, dmem_req, me_mem_exc);
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    me_valid   = 1'b0;
    checks++;
    if (me_mem_rdata !== held || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_hold: rdata=%h req=%b want %h 0", name, me_mem_rdata, dmem_req,
               held);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    me_valid     = 1'b0;
    me_mem_read  = 1'b0;
    me_mem_write = 1'b0;
    me_funct3    = 3'd0;
    me_addr      = 32'h0;
    me_wdata     = 32'h0;
    dmem_ready   = 1'b0;
    dmem_rdata   = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'b0 || dmem_addr !== 32'h0 ||
        dmem_wdata !== 32'h0 || me_mem_rdata !== 32'h0 || me_stall !== 1'b0 ||
        me_mem_exc !== 1'b0) begin
      failures++;
      $display("FAIL reset: req=%b we=%b be=%b addr=%h wd=%h rd=%h stall=%b exc=%b want all 0",
               dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, me_mem_rdata, me_stall,
               me_mem_exc);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait_loads();
    do_access("lw", 1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF,
              32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    idle_cycle("lw");
    do_access("lb", 1'b0, 3'd0, 32'h103, 32'h0, 0, 32'hDEADBEEF,
              32'h100, 4'b1000, 32'h0, 32'hFFFFFFDE);
    idle_cycle("lb");
    do_access("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 0, 32'hDEADBEEF,
              32'h100, 4'b1000, 32'h0, 32'h000000DE);
    idle_cycle("lbu");
    do_access("lh", 1'b0, 3'd1, 32'h102, 32'h0, 0, 32'hDEADBEEF,
              32'h100, 4'b1100, 32'h0, 32'hFFFFDEAD);
    idle_cycle("lh");
    do_access("lhu", 1'b0, 3'd5, 32'h100, 32'h0, 0, 32'hDEADBEEF,
              32'h100, 4'b0011, 32'h0, 32'h0000BEEF);
    idle_cycle("lhu");
  endtask

  task automatic test_stores();
    do_access("sb", 1'b1, 3'd0, 32'h201, 32'h55AA0012, 0, 32'h77777777,
              32'h200, 4'b0010, 32'h12121212, 32'h0);
    idle_cycle("sb");
    do_access("sh", 1'b1, 3'd1, 32'h202, 32'h9999ABCD, 0, 32'h77777777,
              32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
    idle_cycle("sh");
  endtask

  task automatic test_wait_states();
    do_access("lw_wait4", 1'b0, 3'd2, 32'h180, 32'h0, 4, 32'h13572468,
              32'h180, 4'b1111, 32'h0, 32'h13572468);
    idle_cycle("lw_wait4");
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] ads [3] = '{32'h102, 32'h101, 32'h100};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      me_valid     = 1'b1;
      me_mem_read  = 1'b1;
      me_mem_write = 1'b0;
      me_funct3    = f3s[i];
      me_addr      = ads[i];
      #1;
      checks++;
      if (me_mem_exc !== 1'b1 || me_stall !== 1'b0 || dmem_req !== 1'b0) begin
        failures++;
        $display("FAIL misaligned%0d: exc=%b stall=%b req=%b want 1 0 0",
                 i, me_mem_exc, me_stall, dmem_req);
      end
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0) begin
        failures++;
        $display("FAIL misaligned%0d_req: got %b want 0", i, dmem_req);
      end
      me_valid = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int reqs;
    reqs = 0;
    @(negedge clk);
    me_valid     = 1'b1;
    me_mem_read  = 1'b1;
    me_mem_write = 1'b0;
    me_funct3    = 3'd2;
    me_addr      = 32'h400;
    dmem_ready   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dmem_req) reqs++;
      else break;
    end
    checks++;
    if (reqs != 16) begin
      failures++;
      $display("FAIL timeout_len: req cycles=%0d want 16", reqs);
    end
    checks++;
    if (me_mem_exc !== 1'b1 || me_mem_rdata !== 32'h0 || me_stall !== 1'b0) begin
      failures++;
      $display("FAIL timeout_done: exc=%b rdata=%h stall=%b want 1 0 0",
               me_mem_exc, me_mem_rdata, me_stall);
    end
    @(negedge clk);
    me_valid = 1'b0;
    #1;
    checks++;
    if (me_mem_exc !== 1'b0 || dmem_req !== 1'b0 || me_stall !== 1'b0) begin
      failures++;
      $display("FAIL timeout_after: exc=%b req=%b stall=%b want 0 0 0",
               me_mem_exc, dmem_req, me_stall);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    me_valid     = 1'b1;
    me_mem_read  = 1'b1;
    me_mem_write = 1'b0;
    me_funct3    = 3'd2;
    me_addr      = 32'h500;
    dmem_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: req=%b want 1", dmem_req);
    end
    me_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || me_mem_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid: req=%b rdata=%h want 0 0", dmem_req, me_mem_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || me_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_release: req=%b stall=%b want 0 0", dmem_req, me_stall);
    end
  endtask

  task automatic test_back_to_back();
    int rises0;
    rises0 = req_rises;
    do_access("b2b_lw", 1'b0, 3'd2, 32'h300, 32'h0, 0, 32'hCAFEF00D,
              32'h300, 4'b1111, 32'h0, 32'hCAFEF00D);
    do_access("b2b_sw", 1'b1, 3'd2, 32'h304, 32'h11223344, 1, 32'h0,
              32'h304, 4'b1111, 32'h11223344, 32'h0);
    idle_cycle("b2b");
    checks++;
    if (req_rises != rises0 + 2) begin
      failures++;
      $display("FAIL b2b_issues: got %0d want 2", req_rises - rises0);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    req_rises = 0;
    req_prev  = 1'b0;
    test_reset();
    test_zero_wait_loads();
    test_stores();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
